edge_linking_stream: RTL and testbench
======================================

Name: edge_linking_stream

Overview:
- Parametrised successor to the fixed 3-row hysteresis linker: accepts a raster stream of per-pixel class codes from non-max suppression / double threshold, one pixel per accepted beat.
- Internally buffers two image lines and builds the 3x3 window itself.
- Emits one binary edge pixel per input pixel, in raster order, ahead of the output writer.
- Adds a valid/ready input handshake, image-border masking, selectable 4/8 connectivity, an end-of-frame flush FSM and a frame-last marker.

Parameters:
- IMG_W, 640, pixels per line (>=3)
- IMG_H, 480, lines per frame (>=2)
- OUT_W, 12, output pixel width; an edge is all-ones, a non-edge is 0
- CONN8, 1, 1 = 8-neighbour linking; 0 = 4-neighbour (N, S, E, W only)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input code valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  3  class code: bit2 = strong, bit1 = weak, bit0 unused
- out_valid  out  1  output pixel valid (no backpressure; downstream always accepts)
- out_data  out  OUT_W  edge pixel
- out_last  out  1  high with the final pixel of a frame

Behaviour:
- Reset and wiring
  - One clock domain.
  - Synchronous, active-high reset; clock port `clk`, reset port `rst`.
  - Reset values: out_valid=0, out_data=0, out_last=0, in_ready=1. Column/row/flush counters are 0 and the FSM is in FILL.
  - Line-buffer RAM is not cleared; border masking makes stale contents invisible.
- Accept and window
  - Accept = in_valid & in_ready.
  - Each accept (or flush injection) shifts one pixel into the window and line buffers.
  - Injected flush pixels are code 0.
- Window centre
  - Centre is the pixel (IMG_W+1) positions earlier in raster order.
  - Centre column/row counters track it.
  - Any neighbour outside the image is forced to code 0: row -1, row IMG_H, column -1 (no wrap from the previous line end), column IMG_W.
- Decision
  - edge = C.strong | (C.weak & any neighbour strong).
  - Neighbour set is 8 cells when CONN8=1, 4 cells when CONN8=0.
  - out_data = edge ? {OUT_W{1'b1}} : 0.
- FSM
  - FILL
    - in_ready=1.
    - Counts IMG_W+1 accepts with no output.
    - On the (IMG_W+1)th accept, go to RUN.
  - RUN
    - in_ready=1.
    - Each accept produces one output registered on the next cycle: out_valid=1 for exactly one cycle, latency 1.
    - When the accept is the last input pixel of the frame (index IMG_W*IMG_H-1), go to FLUSH.
  - FLUSH
    - in_ready=0.
    - Injects IMG_W+1 zero pixels on consecutive cycles; each produces one output (out_valid continuous).
    - out_last is asserted with the output whose centre is (IMG_H-1, IMG_W-1).
    - Then go to FILL; the next frame may be accepted the cycle after the FLUSH→FILL transition.
- Totals and boundaries
  - Every frame yields exactly IMG_W*IMG_H outputs.
  - in_valid gaps stall the pipe: no output in gap cycles, state held.
  - in_valid while in_ready=0 is ignored; data is not captured.
  - Reset mid-frame or mid-flush discards the partial frame and returns to FILL with the reset values above.
- Widths
  - Counters are $clog2(IMG_W+1) and $clog2(IMG_H) bits wide.
  - Line buffers are 2 x IMG_W x 3 bits.

Optional Feature:
- Macro: EDGE_LINKING_STATS_EN.
- When defined, adds two ports:
  - edge_count  out  $clog2(IMG_W*IMG_H+1)  number of edge pixels in the last completed frame
  - stats_valid  out  1  one-cycle pulse the cycle after the out_last output
- Counting: an internal counter increments on each out_valid with edge=1. It is latched into edge_count on out_last and cleared for the next frame.
- Reset values: edge_count=0, stats_valid=0.
- When undefined, neither port nor counter exists and the logic is identical otherwise.

Test Plan (IMG_W=4, IMG_H=3, OUT_W=12 unless noted):
- Single-edge frame: 12 codes all 0 except a strong pixel at (1,1) → 12 outputs; only pixel (1,1) = 4095; out_last on the 12th output; first output appears 1 cycle after the 6th accept.
- Weak linking, CONN8=1: strong at (0,0), weak at (1,1) → both 4095. Same frame with CONN8=0 → (1,1)=0.
- Row wrap: strong at (0,3), weak at (1,0) → (1,0)=0 (no wrap adjacency). Weak at (1,3) instead → (1,3)=4095.
- Handshake: in_valid toggled every other cycle → same 12 output values as the continuous run; in_ready=0 for exactly 5 cycles during FLUSH; in_data presented then is not consumed.
- Reset mid-frame: rst asserted after 7 accepts, then a full clean frame → all outputs reset to 0 immediately; the clean frame yields the correct 12 pixels with no residue.
- With EDGE_LINKING_STATS_EN: frame with 3 edge pixels → edge_count=3 and stats_valid pulses once, 1 cycle after out_last.

Source files
------------

// File: rtl/edge_linking_stream.sv
// rtl/edge_linking_stream.sv - streaming 3x3 hysteresis edge linker with line buffers and end-of-frame flush
// Optional statistics ports are enabled by defining EDGE_LINKING_STATS_EN.
module edge_linking_stream #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int OUT_W = 12,
    parameter int CONN8 = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
`ifdef EDGE_LINKING_STATS_EN
    ,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0] edge_count,
    output logic                             stats_valid
`endif
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = $clog2(IMG_W);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, in_col, c_col;
    logic [RW-1:0]   in_row, c_row;
    logic [2:0]      lb_top [IMG_W];
    logic [2:0]      lb_mid [IMG_W];
    // Window columns packed {top, mid, bottom}; col_r is the column arriving this shift
    logic [8:0]      col_l, col_m, col_r;
    logic [2:0]      din;
    logic [AW-1:0]   lb_idx;
    logic            shift, produce, edge_px, last_centre;
    logic            up, dn, lf, rt, nb4, nbd;

    assign in_ready = (state != FLUSH);
    assign shift    = (state == FLUSH) | (in_valid & in_ready);
    assign produce  = shift & (state != FILL);
    assign din      = (state == FLUSH) ? 3'd0 : in_data;
    assign lb_idx   = in_col[AW-1:0];
    assign col_r    = {lb_top[lb_idx], lb_mid[lb_idx], din};

    // Neighbours beyond the image edge read as code 0
    assign up = (c_row != '0);
    assign dn = (c_row != RW'(IMG_H - 1));
    assign lf = (c_col != '0);
    assign rt = (c_col != CW'(IMG_W - 1));

    assign nb4 = (col_m[8] & up) | (col_m[2] & dn) | (col_l[5] & lf) | (col_r[5] & rt);
    assign nbd = (col_l[8] & up & lf) | (col_l[2] & dn & lf) |
                 (col_r[8] & up & rt) | (col_r[2] & dn & rt);
    assign edge_px     = col_m[5] | (col_m[4] & (nb4 | ((CONN8 != 0) & nbd)));
    assign last_centre = (c_row == RW'(IMG_H - 1)) & (c_col == CW'(IMG_W - 1));

    logic unused_bits;
    assign unused_bits = ^{col_l[7:6], col_l[4:3], col_l[1:0], col_m[7:6], col_m[3],
                           col_m[1:0], col_r[7:6], col_r[4:3], col_r[1:0]};

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (shift && cnt == CW'(IMG_W)) state_nxt = RUN;
            RUN:     if (shift && in_row == RW'(IMG_H - 1) && in_col == CW'(IMG_W - 1))
                         state_nxt = FLUSH;
            FLUSH:   if (cnt == CW'(IMG_W)) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            in_col    <= '0;
            in_row    <= '0;
            c_col     <= '0;
            c_row     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= produce;
            out_data  <= (produce && edge_px) ? {OUT_W{1'b1}} : '0;
            out_last  <= produce & last_centre;
            if (shift) begin
                if (state != RUN)
                    cnt <= (cnt == CW'(IMG_W)) ? '0 : cnt + CW'(1);
                if (state == FLUSH && cnt == CW'(IMG_W)) begin
                    in_col <= '0;
                    in_row <= '0;
                end else begin
                    in_col <= (in_col == CW'(IMG_W - 1)) ? '0 : in_col + CW'(1);
                    if (state != FLUSH && in_col == CW'(IMG_W - 1))
                        in_row <= (in_row == RW'(IMG_H - 1)) ? '0 : in_row + RW'(1);
                end
            end
            if (produce) begin
                c_col <= (c_col == CW'(IMG_W - 1)) ? '0 : c_col + CW'(1);
                if (c_col == CW'(IMG_W - 1))
                    c_row <= (c_row == RW'(IMG_H - 1)) ? '0 : c_row + RW'(1);
            end
        end
    end

    // Pixel storage is never cleared; border masking hides stale contents
    always_ff @(posedge clk) begin
        if (shift) begin
            lb_top[lb_idx] <= lb_mid[lb_idx];
            lb_mid[lb_idx] <= din;
            col_l          <= col_m;
            col_m          <= col_r;
        end
    end

`ifdef EDGE_LINKING_STATS_EN
    localparam int EW = $clog2(IMG_W*IMG_H + 1);
    logic [EW-1:0] edge_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_acc    <= '0;
            edge_count  <= '0;
            stats_valid <= 1'b0;
        end else begin
            stats_valid <= out_valid & out_last;
            if (out_valid && out_last) begin
                edge_count <= edge_acc + EW'(out_data[0]);
                edge_acc   <= '0;
            end else if (out_valid && out_data[0]) begin
                edge_acc <= edge_acc + EW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_edge_linking_stream.sv
// tb/tb_edge_linking_stream.sv - directed bench for edge_linking_stream, 4x3 frames, 8- and 4-connected instances
module tb_edge_linking_stream;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int OW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [2:0]    in_data;
    logic          rdy8, ov8, ol8, rdy4, ov4, ol4;
    logic [OW-1:0] od8, od4;
`ifdef EDGE_LINKING_STATS_EN
    logic [3:0]    ec8, ec4;
    logic          sv8, sv4;
`endif

    always #5 clk = ~clk;

    edge_linking_stream #(.IMG_W(W), .IMG_H(H), .OUT_W(OW), .CONN8(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data),
        .out_valid(ov8), .out_data(od8), .out_last(ol8)
`ifdef EDGE_LINKING_STATS_EN
        , .edge_count(ec8), .stats_valid(sv8)
`endif
    );

    edge_linking_stream #(.IMG_W(W), .IMG_H(H), .OUT_W(OW), .CONN8(0)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
        .out_valid(ov4), .out_data(od4), .out_last(ol4)
`ifdef EDGE_LINKING_STATS_EN
        , .edge_count(ec4), .stats_valid(sv4)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output capture; the main process only reads these
    logic [OW-1:0] got8 [256];
    logic [OW-1:0] got4 [256];
    logic          lst8 [256];
    logic          lst4 [256];
    int            tot8 = 0;
    int            tot4 = 0;

    always @(negedge clk) begin
        if (ov8 && tot8 < 256) begin
            got8[tot8] <= od8;
            lst8[tot8] <= ol8;
            tot8       <= tot8 + 1;
        end
        if (ov4 && tot4 < 256) begin
            got4[tot4] <= od4;
            lst4[tot4] <= ol4;
            tot4       <= tot4 + 1;
        end
    end

`ifdef EDGE_LINKING_STATS_EN
    int   svn8 = 0, svn4 = 0, late8 = 0, late4 = 0;
    int   sec8 = 0, sec4 = 0;
    logic pl8 = 1'b0, pl4 = 1'b0;

    always @(negedge clk) begin
        pl8 <= ov8 & ol8;
        pl4 <= ov4 & ol4;
        if (sv8) begin
            svn8  <= svn8 + 1;
            sec8  <= int'(ec8);
            late8 <= late8 + (pl8 ? 0 : 1);
        end
        if (sv4) begin
            svn4  <= svn4 + 1;
            sec4  <= int'(ec4);
            late4 <= late4 + (pl4 ? 0 : 1);
        end
    end
`endif

    function automatic logic [35:0] mk(input logic [11:0] s, input logic [11:0] w);
        logic [35:0] f;
        f = '0;
        for (int i = 0; i < 12; i++) f[3*i +: 3] = {s[i], w[i], 1'b0};
        return f;
    endfunction

    task automatic send(input logic [35:0] f, input bit gap, input int n);
        for (int i = 0; i < n; i++) begin
            int tries;
            tries    = 0;
            in_valid = 1'b1;
            in_data  = f[3*i +: 3];
            while (!rdy8 && tries < 20) begin
                @(posedge clk); #1;
                tries++;
            end
            if (tries >= 20) check("ready_timeout", 0, 1);
            @(posedge clk); #1;
            check($sformatf("latency[%0d]", i), int'(ov8), (i >= 5) ? 1 : 0);
            if (gap && i < n - 1) begin
                in_valid = 1'b0;
                in_data  = 3'b100;
                @(posedge clk); #1;
                check($sformatf("gap_out[%0d]", i), int'(ov8), 0);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic [11:0] s, input logic [11:0] w,
                             input logic [11:0] e8, input logic [11:0] e4, input bit gap);
        int b8, b4, zeros;
`ifdef EDGE_LINKING_STATS_EN
        int bs8, bs4;
        bs8 = svn8;
        bs4 = svn4;
`endif
        b8 = tot8;
        b4 = tot4;
        send(mk(s, w), gap, 12);
        // Present a strong pixel throughout the flush; it must be ignored
        in_valid = 1'b1;
        in_data  = 3'b100;
        zeros    = 0;
        while (!rdy8 && zeros < 20) begin
            zeros++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 3'b000;
        check({name, " flush_not_ready"}, zeros, 5);
        repeat (3) @(negedge clk);
        #1;
        check({name, " count8"}, tot8 - b8, 12);
        check({name, " count4"}, tot4 - b4, 12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s px8[%0d]", name, i), int'(got8[b8+i]), e8[i] ? 4095 : 0);
            check($sformatf("%s px4[%0d]", name, i), int'(got4[b4+i]), e4[i] ? 4095 : 0);
            check($sformatf("%s last8[%0d]", name, i), int'(lst8[b8+i]), (i == 11) ? 1 : 0);
        end
`ifdef EDGE_LINKING_STATS_EN
        check({name, " stats_pulses8"}, svn8 - bs8, 1);
        check({name, " stats_pulses4"}, svn4 - bs4, 1);
        check({name, " edge_count8"}, sec8, $countones(e8));
        check({name, " edge_count4"}, sec4, $countones(e4));
        check({name, " stats_timing"}, late8 + late4, 0);
`endif
    endtask

    initial begin
        int b8;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", int'(ov8), 0);
        check("reset out_data", int'(od8), 0);
        check("reset out_last", int'(ol8), 0);
        check("reset in_ready", int'(rdy8), 1);
`ifdef EDGE_LINKING_STATS_EN
        check("reset edge_count", int'(ec8), 0);
        check("reset stats_valid", int'(sv8), 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame("single", 12'h020, 12'h000, 12'h020, 12'h020, 1'b0);
        run_frame("diag",   12'h001, 12'h020, 12'h021, 12'h001, 1'b0);
        run_frame("nowrap", 12'h008, 12'h010, 12'h008, 12'h008, 1'b0);
        run_frame("north",  12'h008, 12'h080, 12'h088, 12'h088, 1'b0);
        run_frame("gaps",   12'h001, 12'h020, 12'h021, 12'h001, 1'b1);
        run_frame("chain",  12'h001, 12'h060, 12'h021, 12'h001, 1'b0);
        run_frame("corner", 12'h801, 12'h400, 12'hC01, 12'hC01, 1'b0);

        // Abort a frame after 7 accepts
        b8 = tot8;
        send(mk(12'h801, 12'h400), 1'b0, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset out_valid", int'(ov8), 0);
        check("midreset out_data", int'(od8), 0);
        check("midreset out_last", int'(ol8), 0);
        check("midreset in_ready", int'(rdy8), 1);
        rst = 1'b0;
        @(negedge clk); #1;
        check("partial outputs", tot8 - b8, 2);
        check("partial px0", int'(got8[b8]), 4095);
        check("partial px1", int'(got8[b8+1]), 0);
        @(posedge clk); #1;

        run_frame("allweak", 12'h000, 12'hFFF, 12'h000, 12'h000, 1'b0);
        run_frame("clean",   12'h020, 12'h000, 12'h020, 12'h020, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
